// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared geometry, tap tables, state encoding and default
//                widths for the 3x3-over-4x4 convolution engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int IMG_N     = 4;            // image is IMG_N x IMG_N
    localparam int K_N       = 3;            // kernel is K_N x K_N
    localparam int OUT_N     = 2;            // valid region is OUT_N x OUT_N
    localparam int N_TAPS    = K_N * K_N;
    localparam int DEF_PIX_W = 4;
    localparam int DEF_ACC_W = 11;

    // Tap j -> kernel row (j/3) and column (j%3); element [j] of each table.
    localparam logic [N_TAPS-1:0][1:0] TAP_KR = {
        2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0
    };
    localparam logic [N_TAPS-1:0][1:0] TAP_KC = {
        2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Row-major image address of the pixel under tap 'tap' for output 'pos'.
    // Row and column never exceed 3, so the address is simply {row, col}.
    function automatic logic [3:0] img_index(input logic [1:0] pos,
                                             input logic [3:0] tap);
        logic [1:0] row;
        logic [1:0] col;
        row = {1'b0, pos[1]} + TAP_KR[tap];
        col = {1'b0, pos[0]} + TAP_KC[tap];
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac
//  Description : Unsigned PIX_W x PIX_W multiplier feeding an ACC_W
//                accumulator with synchronous clear and accumulate enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac #(
    parameter int PIX_W = 4,
    parameter int ACC_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [PIX_W-1:0] pix,
    input  logic [PIX_W-1:0] coef,
    output logic [ACC_W-1:0] acc
);

    logic [2*PIX_W-1:0] w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   r_acc;

    assign w_prod     = {{PIX_W{1'b0}}, pix} * {{PIX_W{1'b0}}, coef};
    assign w_prod_ext = {{(ACC_W-2*PIX_W){1'b0}}, w_prod};

    // Accumulator: clear has priority; 9 full-scale products fit in ACC_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/conv_mac_engine.sv
`default_nettype none
// ============================================================================
//  Module      : conv_mac_engine
//  Description : 3x3 convolution over a locally stored 4x4 image, sequenced
//                by the one-hot timing vector T; one result per 16-step frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      T,
    input  logic             start,
    input  logic             img_we,
    input  logic [3:0]       img_addr,
    input  logic [PIX_W-1:0] img_data,
    input  logic             krn_we,
    input  logic [3:0]       krn_addr,
    input  logic [PIX_W-1:0] krn_data,
    output logic             busy,
    output logic             out_valid,
    output logic [1:0]       out_idx,
    output logic [ACC_W-1:0] out_data,
    output logic             done,
    output logic             t_err
);

    state_t           r_state;
    logic [1:0]       r_pos;
    logic             r_busy;
    logic             r_out_valid;
    logic             r_done;
    logic             r_t_err;
    logic [1:0]       r_out_idx;
    logic [ACC_W-1:0] r_out_data;

    logic [PIX_W-1:0] r_img [0:IMG_N*IMG_N-1];
    logic [PIX_W-1:0] r_krn [0:N_TAPS-1];

    logic             w_onehot;
    logic             w_t0;
    logic [3:0]       w_tap;
    logic [3:0]       w_addr;
    logic             w_clr;
    logic             w_en;
    logic [ACC_W-1:0] w_acc;

    assign w_onehot = (T != 16'h0000) && ((T & (T - 16'h0001)) == 16'h0000);
    assign w_t0     = (T == 16'h0001);

    // Tap number of the active T[1..9] bit (only meaningful when w_en is set).
    always_comb begin
        w_tap = 4'd0;
        for (int k = 1; k <= N_TAPS; k++) begin
            if (T[k]) begin
                w_tap = 4'(k - 1);
            end
        end
    end

    assign w_addr = img_index(r_pos, w_tap);

    // The clear also fires on the ARMED->RUN transition cycle, since that
    // cycle carries the T[0] action of the first frame.
    assign w_clr = ((r_state == ARMED) || (r_state == RUN)) && w_t0;
    assign w_en  = (r_state == RUN) && w_onehot && (|T[9:1]);

    conv_mac #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_en),
        .pix   (r_img[w_addr]),
        .coef  (r_krn[w_tap]),
        .acc   (w_acc)
    );

    // Image and kernel stores: writable only while idle; taps above 8 dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_N*IMG_N; i++) begin
                r_img[i] <= '0;
            end
            for (int i = 0; i < N_TAPS; i++) begin
                r_krn[i] <= '0;
            end
        end else if (!r_busy) begin
            if (img_we) begin
                r_img[img_addr] <= img_data;
            end
            if (krn_we && (krn_addr < 4'(N_TAPS))) begin
                r_krn[krn_addr] <= krn_data;
            end
        end
    end

    // Run sequencer with registered status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pos       <= 2'd0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_t_err     <= 1'b0;
            r_out_idx   <= 2'd0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                        r_pos   <= 2'd0;
                    end
                end
                ARMED: begin
                    if (w_t0) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!w_onehot) begin
                        r_t_err <= 1'b1;
                    end else if (T[10]) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_acc;
                        r_out_idx   <= r_pos;
                        if (r_pos == 2'd3) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_pos <= r_pos + 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_data  = r_out_data;
    assign done      = r_done;
    assign t_err     = r_t_err;

endmodule
`default_nettype wire
